glb_bank_mem_ctrl: RTL and testbench
====================================

# glb_bank_mem_ctrl

Parametrised global-buffer bank memory controller. It sits between the bank's request arbiter and NUM_MACROS single-port SRAM macros. It decodes byte addresses to macro and word, applies per-bit write masks, and returns read data after a configurable fixed latency with hold-last-value semantics. It optionally absorbs read/write collisions in a small write buffer with read forwarding.

## Interface
- DATA_WIDTH, 64: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 17: byte address width.
- BYTE_OFFSET, 3: must equal log2(DATA_WIDTH/8).
- NUM_MACROS, 4: number of SRAM macros; power of 2, ≥1.
- RD_LATENCY, 3: cycles from an accepted ren to data_out_valid; ≥1. The macro contributes 1 cycle; the rest are pipeline registers.
- WBUF_DEPTH, 2: write-buffer entries; ≥1. Used only with GLB_BANK_WBUF_EN.
- clk, input, 1: bank clock; the only clock.
- reset_n, input, 1: synchronous, active-low reset.
- ren, input, 1: read request.
- wen, input, 1: write request.
- addr, input, ADDR_WIDTH: byte address.
- data_in, input, DATA_WIDTH: write data.
- data_in_bit_sel, input, DATA_WIDTH: per-bit write enable; 1 = write that bit.
- wr_ready, output, 1: write may be issued this cycle.
- data_out, output, DATA_WIDTH: read data; holds its last value between reads.
- data_out_valid, output, 1: 1-cycle pulse marking fresh data_out.
- rd_drop, output, 1: 1-cycle pulse, one cycle after a read was discarded.

## Operation
- Word address = addr[ADDR_WIDTH-1:BYTE_OFFSET].
- Macro select = the top log2(NUM_MACROS) bits of the word address; the remaining bits address the macro.
- Only the selected macro has CEB low. Every other macro stays deselected.
- Low addr bits [BYTE_OFFSET-1:0] are ignored.
- The read pipeline carries valid, macro select and the forward snapshot. On the last stage the selected macro's Q is muxed into data_out and data_out_valid pulses.
- Without a valid read, data_out holds its previous value.
- Write with ren=0: write issued to the macro, masked by bit_sel. Never produces data_out_valid.
- ren and wen together, macro compiled without write buffer: the write wins. The read is discarded and rd_drop pulses on the next cycle.
- wr_ready is tied to 1 in that case.

## Timing
- Reset values: data_out=0, data_out_valid=0, rd_drop=0, wr_ready=1. Read pipeline is flushed and the write buffer is emptied.
- Asserting reset_n=0 mid-operation discards in-flight reads (no valid pulse) and buffered writes (never committed).
- Accepted read at cycle T gives data_out_valid at T+RD_LATENCY. Back-to-back reads sustain 1 per cycle.
- A read issued the cycle after a write to the same word returns the new data.
- wen while wr_ready=0 is a protocol violation. The write is ignored.

## Configuration
- GLB_BANK_WBUF_EN defined: ren and wen together sends the read to SRAM and pushes {word addr, data, bit_sel} into an in-order FIFO of WBUF_DEPTH entries.
  - Drain: a cycle with ren=0 commits the oldest entry to SRAM.
  - wen with ren=0 and a non-empty buffer drains the oldest entry and pushes the new write, preserving order.
  - wr_ready = !full.
  - A read whose word matches buffered entries takes a snapshot at issue: entries are merged oldest-to-newest over the SRAM data per bit_sel. The merge is applied at output.
  - rd_drop is never asserted.
- GLB_BANK_WBUF_EN undefined: no buffer logic is instantiated. Collision behaviour is as in Operation.

## Structure
- The shared package global_buffer_param holds bank constants (DATA_WIDTH, ADDR_WIDTH, BYTE_OFFSET, NUM_MACROS, RD_LATENCY, WBUF_DEPTH).
- The shared package also holds the typedef wbuf_entry_t {addr, data, bit_sel}.
- Macros are instantiated as NUM_MACROS copies of glb_bank_sram_gen via generate, with active-low CEB/WEB/BWEB.
- One sub-module, glb_bank_wbuf, holds the FIFO, the address-match compare and the merge logic. It is instantiated only under GLB_BANK_WBUF_EN.

## Test plan
- Reset, write, read back: reset_n low 2 cycles → outputs all 0, wr_ready=1. Write 0xDEADBEEF_01234567 to addr 0x0008 with full mask, then read 0x0008 → data_out_valid exactly 3 cycles after ren, with that value. data_out then holds it.
- Macro decode and mask: write all-ones to the first word of each macro, then write 0 to macro 2 word 0 with bit_sel=0x00000000_FFFFFFFF → reads return 0xFFFFFFFF_00000000 for macro 2 and all-ones for the others. Only one CEB is low per cycle.
- Collision without buffer: ren and wen together at addr 0x10 → write committed, no data_out_valid, rd_drop=1 on the next cycle.
- Collision with buffer (GLB_BANK_WBUF_EN): preload addr 0x20=0. Issue ren@0x20 and wen@0x20 data=0xAA, bit_sel=0xFF together, twice → wr_ready=0 after the second. Both reads return 0xAA (forwarded). An idle cycle drains and wr_ready returns to 1.
- Reset mid-operation: reset_n low with 2 reads in flight and 1 buffered write → no data_out_valid afterwards. A read of that address returns the pre-write value.
- Throughput: 16 back-to-back reads with RD_LATENCY=1 and RD_LATENCY=4 → 16 consecutive valid pulses, correct order.

Source files
------------

// File: rtl/global_buffer_param.sv
// Shared global-buffer bank constants and the write-buffer entry layout.
package global_buffer_param;

  localparam int DATA_WIDTH      = 64;
  localparam int ADDR_WIDTH      = 17;
  localparam int BYTE_OFFSET     = 3;
  localparam int NUM_MACROS      = 4;
  localparam int RD_LATENCY      = 3;
  localparam int WBUF_DEPTH      = 2;
  localparam int WORD_ADDR_WIDTH = ADDR_WIDTH - BYTE_OFFSET;

  typedef struct packed {
    logic [WORD_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]      data;
    logic [DATA_WIDTH-1:0]      bit_sel;
  } wbuf_entry_t;

endpackage

// File: rtl/glb_bank_sram_gen.sv
// Behavioural single-port SRAM macro with active-low chip/write/bit-write enables.
module glb_bank_sram_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  CLK,
  input  logic                  CEB,
  input  logic                  WEB,
  input  logic [DATA_WIDTH-1:0] BWEB,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] q_q;

  // Q only changes on a read access, so it holds across writes and deselected cycles.
  always_ff @(posedge CLK) begin
    if (!CEB) begin
      if (!WEB) begin
        mem_q[A] <= (mem_q[A] & BWEB) | (D & ~BWEB);
      end else begin
        q_q <= mem_q[A];
      end
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/glb_bank_wbuf.sv
// In-order write buffer with word-address match and oldest-to-newest bit merge for read forwarding.
module glb_bank_wbuf
  import global_buffer_param::*;
#(
  parameter int DEPTH = WBUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  wbuf_entry_t                push_entry,
  input  logic                       pop,
  output wbuf_entry_t                head,
  output logic                       full,
  output logic                       empty,
  input  logic [WORD_ADDR_WIDTH-1:0] lookup_addr,
  output logic [DATA_WIDTH-1:0]      fwd_mask,
  output logic [DATA_WIDTH-1:0]      fwd_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wbuf_entry_t      ent_q [DEPTH];
  wbuf_entry_t      ent_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  int               fill;

  assign head  = ent_q[0];
  assign full  = (int'(cnt_q) == DEPTH);
  assign empty = (cnt_q == '0);

  // Entry 0 is always the oldest; a pop shifts down before a same-cycle push lands.
  always_comb begin
    ent_d = ent_q;
    fill  = int'(cnt_q);
    if (pop && fill > 0) begin
      for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i + 1];
      fill = fill - 1;
    end
    if (push && fill < DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == fill) ent_d[i] = push_entry;
      end
      fill = fill + 1;
    end
    cnt_d = CNT_W'(fill);
  end

  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(cnt_q) && ent_q[i].addr == lookup_addr) begin
        fwd_data = (fwd_data & ~ent_q[i].bit_sel) | (ent_q[i].data & ent_q[i].bit_sel);
        fwd_mask = fwd_mask | ent_q[i].bit_sel;
      end
    end
    if (push && !full && push_entry.addr == lookup_addr) begin
      fwd_data = (fwd_data & ~push_entry.bit_sel) | (push_entry.data & push_entry.bit_sel);
      fwd_mask = fwd_mask | push_entry.bit_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: rtl/glb_bank_mem_ctrl.sv
// Bank memory controller: macro decode, masked writes, fixed-latency reads with held output.
// Define GLB_BANK_WBUF_EN to absorb read/write collisions in a forwarding write buffer.
module glb_bank_mem_ctrl #(
  parameter int DATA_WIDTH  = global_buffer_param::DATA_WIDTH,
  parameter int ADDR_WIDTH  = global_buffer_param::ADDR_WIDTH,
  parameter int BYTE_OFFSET = global_buffer_param::BYTE_OFFSET,
  parameter int NUM_MACROS  = global_buffer_param::NUM_MACROS,
  parameter int RD_LATENCY  = global_buffer_param::RD_LATENCY,
  parameter int WBUF_DEPTH  = global_buffer_param::WBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ren,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_in_bit_sel,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  rd_drop
);

  localparam int WADDR_W = ADDR_WIDTH - BYTE_OFFSET;
  localparam int MSEL_W  = (NUM_MACROS > 1) ? $clog2(NUM_MACROS) : 1;
  localparam int MADDR_W = (NUM_MACROS > 1) ? WADDR_W - MSEL_W : WADDR_W;

  logic [WADDR_W-1:0]                     word_addr;
  logic                                   rd_issue, port_en, port_we;
  logic                                   rd_drop_d, rd_drop_q;
  logic [WADDR_W-1:0]                     port_addr;
  logic [DATA_WIDTH-1:0]                  port_data, port_bit_sel;
  logic [MSEL_W-1:0]                      port_msel, msel_d, msel_q;
  logic [MADDR_W-1:0]                     port_maddr;
  logic [NUM_MACROS-1:0][DATA_WIDTH-1:0]  macro_q;
  logic [DATA_WIDTH-1:0]                  q_mux, last_data, merged, hold_d, hold_q;
  logic [RD_LATENCY-1:0]                  vld_d, vld_q;

  assign word_addr = addr[ADDR_WIDTH-1:BYTE_OFFSET];

  if (BYTE_OFFSET > 0) begin : g_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[BYTE_OFFSET-1:0];
  end

`ifdef GLB_BANK_WBUF_EN
  global_buffer_param::wbuf_entry_t push_entry, drain_entry;
  logic                  push, drain, full, empty;
  logic [DATA_WIDTH-1:0] fwd_mask, fwd_data;
  logic [DATA_WIDTH-1:0] fmask_d [RD_LATENCY];
  logic [DATA_WIDTH-1:0] fmask_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] fdata_d [RD_LATENCY];
  logic [DATA_WIDTH-1:0] fdata_q [RD_LATENCY];

  assign push_entry = '{addr: word_addr, data: data_in, bit_sel: data_in_bit_sel};
  assign wr_ready   = !full;

  // Reads always own the port; idle-read cycles retire the oldest buffered write first.
  always_comb begin
    rd_issue     = ren;
    drain        = !ren && !empty;
    push         = wen && !full && (ren || !empty);
    port_en      = ren || drain || (wen && !full);
    port_we      = !ren && (drain || (wen && !full));
    port_addr    = drain ? drain_entry.addr    : word_addr;
    port_data    = drain ? drain_entry.data    : data_in;
    port_bit_sel = drain ? drain_entry.bit_sel : data_in_bit_sel;
    rd_drop_d    = 1'b0;
  end

  glb_bank_wbuf #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (drain),
    .head        (drain_entry),
    .full        (full),
    .empty       (empty),
    .lookup_addr (word_addr),
    .fwd_mask    (fwd_mask),
    .fwd_data    (fwd_data)
  );

  always_comb begin
    fmask_d[0] = fwd_mask;
    fdata_d[0] = fwd_data;
    for (int i = 1; i < RD_LATENCY; i++) begin
      fmask_d[i] = fmask_q[i-1];
      fdata_d[i] = fdata_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    fmask_q <= fmask_d;
    fdata_q <= fdata_d;
  end

  assign merged = (last_data & ~fmask_q[RD_LATENCY-1]) |
                  (fdata_q[RD_LATENCY-1] & fmask_q[RD_LATENCY-1]);
`else
  assign wr_ready = 1'b1;

  // A colliding write takes the port; the read is dropped and reported a cycle later.
  always_comb begin
    rd_issue     = ren && !wen;
    port_en      = ren || wen;
    port_we      = wen;
    port_addr    = word_addr;
    port_data    = data_in;
    port_bit_sel = data_in_bit_sel;
    rd_drop_d    = ren && wen;
  end

  assign merged = last_data;
`endif

  if (NUM_MACROS > 1) begin : g_msel
    assign port_msel = port_addr[WADDR_W-1 -: MSEL_W];
  end else begin : g_msel_one
    assign port_msel = '0;
  end
  assign port_maddr = port_addr[MADDR_W-1:0];

  // Every macro access is held off during reset so a pending drain cannot commit.
  for (genvar g = 0; g < NUM_MACROS; g++) begin : g_macro
    logic ceb;
    assign ceb = !(reset_n && port_en && (port_msel == MSEL_W'(g)));
    glb_bank_sram_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (MADDR_W)
    ) u_sram (
      .CLK  (clk),
      .CEB  (ceb),
      .WEB  (!port_we),
      .BWEB (~port_bit_sel),
      .A    (port_maddr),
      .D    (port_data),
      .Q    (macro_q[g])
    );
  end

  // Q is captured right after the macro cycle so back-to-back reads cannot overwrite it.
  assign q_mux = macro_q[msel_q];

  if (RD_LATENCY == 1) begin : g_lat_one
    assign last_data = q_mux;
  end else begin : g_lat_pipe
    logic [DATA_WIDTH-1:0] data_d [RD_LATENCY-1];
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY-1];
    always_comb begin
      data_d[0] = q_mux;
      for (int i = 1; i < RD_LATENCY - 1; i++) data_d[i] = data_q[i-1];
    end
    always_ff @(posedge clk) begin
      data_q <= data_d;
    end
    assign last_data = data_q[RD_LATENCY-2];
  end

  always_comb begin
    data_out = hold_q;
    if (vld_q[RD_LATENCY-1]) data_out = merged;
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_issue;
    for (int i = 1; i < RD_LATENCY; i++) vld_d[i] = vld_q[i-1];
    msel_d = rd_issue ? port_msel : msel_q;
    hold_d = data_out;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q     <= '0;
      msel_q    <= '0;
      rd_drop_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      vld_q     <= vld_d;
      msel_q    <= msel_d;
      rd_drop_q <= rd_drop_d;
      hold_q    <= hold_d;
    end
  end

  assign data_out_valid = vld_q[RD_LATENCY-1];
  assign rd_drop        = rd_drop_q;

endmodule

// File: tb/tb_glb_bank_mem_ctrl.sv
// Directed bench for glb_bank_mem_ctrl; three instances share stimulus at read latencies 3, 1 and 4.
module tb_glb_bank_mem_ctrl;

  localparam int DW = 64;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset_n, ren, wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in, bit_sel;

  logic          wr_ready, data_out_valid, rd_drop;
  logic [DW-1:0] data_out;
  logic          wr_ready_l1, data_out_valid_l1, rd_drop_l1;
  logic [DW-1:0] data_out_l1;
  logic          wr_ready_l4, data_out_valid_l4, rd_drop_l4;
  logic [DW-1:0] data_out_l4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  glb_bank_mem_ctrl u_dut (
    .clk (clk), .reset_n (reset_n), .ren (ren), .wen (wen), .addr (addr),
    .data_in (data_in), .data_in_bit_sel (bit_sel), .wr_ready (wr_ready),
    .data_out (data_out), .data_out_valid (data_out_valid), .rd_drop (rd_drop)
  );

  glb_bank_mem_ctrl #(.RD_LATENCY(1)) u_dut_l1 (
    .clk (clk), .reset_n (reset_n), .ren (ren), .wen (wen), .addr (addr),
    .data_in (data_in), .data_in_bit_sel (bit_sel), .wr_ready (wr_ready_l1),
    .data_out (data_out_l1), .data_out_valid (data_out_valid_l1), .rd_drop (rd_drop_l1)
  );

  glb_bank_mem_ctrl #(.RD_LATENCY(4)) u_dut_l4 (
    .clk (clk), .reset_n (reset_n), .ren (ren), .wen (wen), .addr (addr),
    .data_in (data_in), .data_in_bit_sel (bit_sel), .wr_ready (wr_ready_l4),
    .data_out (data_out_l4), .data_out_valid (data_out_valid_l4), .rd_drop (rd_drop_l4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    ren = 1'b0; wen = 1'b1; addr = a; data_in = d; bit_sel = m;
    tick();
    wen = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; data_in = '0; bit_sel = '0;
    tick();
    tick();
    total++; if (data_out !== 64'h0) begin bad++; $display("[TB] FAIL reset_data_out: got %h want 0", data_out); end
    total++; if (data_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", data_out_valid); end
    total++; if (rd_drop !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_drop: got %b want 0", rd_drop); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_wr_ready: got %b want 1", wr_ready); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic exp_v;
    do_write(17'h00008, 64'hDEADBEEF_01234567, '1);
    ren = 1'b1; addr = 17'h00008;
    tick();
    ren = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      exp_v = (c == 3);
      total++; if (data_out_valid !== exp_v) begin bad++; $display("[TB] FAIL wr_rd_valid c%0d: got %b want %b", c, data_out_valid, exp_v); end
      if (c >= 3) begin
        total++; if (data_out !== 64'hDEADBEEF_01234567) begin bad++; $display("[TB] FAIL wr_rd_data c%0d: got %h want deadbeef01234567", c, data_out); end
      end
      tick();
    end
  endtask

  task automatic test_decode_mask();
    logic [AW-1:0] rd_addr [6];
    logic [DW-1:0] exp_d   [6];
    logic          exp_v;
    rd_addr = '{17'h00000, 17'h08000, 17'h10000, 17'h18000, 17'h10005, 17'h00008};
    exp_d   = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_00000000,
                64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_00000000, 64'hDEADBEEF_01234567};
    for (int m = 0; m < 4; m++) do_write(rd_addr[m], '1, '1);
    do_write(17'h10000, 64'h0, 64'h00000000_FFFFFFFF);
    for (int c = 0; c < 10; c++) begin
      exp_v = (c >= 3 && c < 9);
      total++; if (data_out_valid !== exp_v) begin bad++; $display("[TB] FAIL decode_valid c%0d: got %b want %b", c, data_out_valid, exp_v); end
      if (exp_v) begin
        total++; if (data_out !== exp_d[c-3]) begin bad++; $display("[TB] FAIL decode_data r%0d: got %h want %h", c - 3, data_out, exp_d[c-3]); end
      end
      ren = (c < 6);
      if (c < 6) addr = rd_addr[c];
      tick();
    end
  endtask

`ifdef GLB_BANK_WBUF_EN
  task automatic test_collision();
    logic [DW-1:0] exp_d;
    exp_d = 64'hFFFF0000_FFFF00AA;
    do_write(17'h00020, 64'hFFFF0000_FFFF0000, '1);
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL wbuf_ready_t0: got %b want 1", wr_ready); end
    ren = 1'b1; wen = 1'b1; addr = 17'h00020; data_in = 64'hAA; bit_sel = 64'hFF;
    tick();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL wbuf_ready_t1: got %b want 1", wr_ready); end
    tick();
    total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL wbuf_ready_full: got %b want 0", wr_ready); end
    data_in = 64'hCC;
    tick();
    ren = 1'b0; wen = 1'b0;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL wbuf_ready_t3: got %b want 0", wr_ready); end
    for (int c = 3; c <= 6; c++) begin
      total++; if (data_out_valid !== (c <= 5)) begin bad++; $display("[TB] FAIL wbuf_valid c%0d: got %b want %b", c, data_out_valid, c <= 5); end
      if (c <= 5) begin
        total++; if (data_out !== exp_d) begin bad++; $display("[TB] FAIL wbuf_fwd_data c%0d: got %h want %h", c, data_out, exp_d); end
      end
      total++; if (rd_drop !== 1'b0) begin bad++; $display("[TB] FAIL wbuf_rd_drop c%0d: got %b want 0", c, rd_drop); end
      if (c == 4) begin
        total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL wbuf_ready_drained: got %b want 1", wr_ready); end
      end
      tick();
    end
    ren = 1'b1; addr = 17'h00020;
    tick();
    ren = 1'b0;
    tick();
    tick();
    total++; if (data_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL wbuf_commit_valid: got %b want 1", data_out_valid); end
    total++; if (data_out !== exp_d) begin bad++; $display("[TB] FAIL wbuf_commit_data: got %h want %h", data_out, exp_d); end
    tick();
  endtask
`else
  task automatic test_collision();
    do_write(17'h00010, 64'h11111111_11111111, '1);
    ren = 1'b1; wen = 1'b1; addr = 17'h00010; data_in = 64'h5A5A5A5A_A5A5A5A5; bit_sel = '1;
    tick();
    ren = 1'b0; wen = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total++; if (rd_drop !== (c == 1)) begin bad++; $display("[TB] FAIL coll_rd_drop c%0d: got %b want %b", c, rd_drop, c == 1); end
      total++; if (data_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL coll_no_valid c%0d: got %b want 0", c, data_out_valid); end
      tick();
    end
    ren = 1'b1; addr = 17'h00010;
    tick();
    ren = 1'b0;
    tick();
    tick();
    total++; if (data_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL coll_commit_valid: got %b want 1", data_out_valid); end
    total++; if (data_out !== 64'h5A5A5A5A_A5A5A5A5) begin bad++; $display("[TB] FAIL coll_commit_data: got %h want 5a5a5a5aa5a5a5a5", data_out); end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    do_write(17'h00028, 64'h0BADF00D_CAFEF00D, '1);
    ren = 1'b1; addr = 17'h00028;
`ifdef GLB_BANK_WBUF_EN
    wen = 1'b1; data_in = 64'h77777777_77777777; bit_sel = '1;
`endif
    tick();
    wen = 1'b0;
    tick();
    ren = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_wr_ready: got %b want 1", wr_ready); end
    total++; if (data_out !== 64'h0) begin bad++; $display("[TB] FAIL rstmid_data_out: got %h want 0", data_out); end
    for (int c = 3; c <= 6; c++) begin
      total++; if (data_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_no_valid c%0d: got %b want 0", c, data_out_valid); end
      tick();
    end
    ren = 1'b1; addr = 17'h00028;
    tick();
    ren = 1'b0;
    tick();
    tick();
    total++; if (data_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_read_valid: got %b want 1", data_out_valid); end
    total++; if (data_out !== 64'h0BADF00D_CAFEF00D) begin bad++; $display("[TB] FAIL rstmid_read_data: got %h want 0badf00dcafef00d", data_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [16];
    logic          exp_v;
    for (int i = 0; i < 16; i++) begin
      exp_d[i] = {16'hC0DE, 16'(i), 32'hA5A50000 + 32'(i)};
      do_write(AW'(i * 8), exp_d[i], '1);
    end
    for (int c = 0; c < 22; c++) begin
      exp_v = (c >= 3 && c < 19);
      total++; if (data_out_valid !== exp_v) begin bad++; $display("[TB] FAIL b2b_l3_valid c%0d: got %b want %b", c, data_out_valid, exp_v); end
      if (exp_v) begin
        total++; if (data_out !== exp_d[c-3]) begin bad++; $display("[TB] FAIL b2b_l3_data c%0d: got %h want %h", c, data_out, exp_d[c-3]); end
      end
      exp_v = (c >= 1 && c < 17);
      total++; if (data_out_valid_l1 !== exp_v) begin bad++; $display("[TB] FAIL b2b_l1_valid c%0d: got %b want %b", c, data_out_valid_l1, exp_v); end
      if (exp_v) begin
        total++; if (data_out_l1 !== exp_d[c-1]) begin bad++; $display("[TB] FAIL b2b_l1_data c%0d: got %h want %h", c, data_out_l1, exp_d[c-1]); end
      end
      exp_v = (c >= 4 && c < 20);
      total++; if (data_out_valid_l4 !== exp_v) begin bad++; $display("[TB] FAIL b2b_l4_valid c%0d: got %b want %b", c, data_out_valid_l4, exp_v); end
      if (exp_v) begin
        total++; if (data_out_l4 !== exp_d[c-4]) begin bad++; $display("[TB] FAIL b2b_l4_data c%0d: got %h want %h", c, data_out_l4, exp_d[c-4]); end
      end
      ren = (c < 16);
      addr = AW'(c * 8);
      tick();
    end
    ren = 1'b0;
    total++; if (data_out_l4 !== exp_d[15]) begin bad++; $display("[TB] FAIL b2b_l4_hold: got %h want %h", data_out_l4, exp_d[15]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_decode_mask();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
